// File: rtl/com_frame_sequencer_pkg.sv
// Shared widths, defaults and state encoding for the COM frame sequencer.
package com_frame_sequencer_pkg;

  localparam int X_W          = 11;
  localparam int Y_W          = 10;
  localparam int CNT_W        = 20;
  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT_SOF,
    ACCUM,
    DRAIN,
    TAB,
    RESULT,
    MISS
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/com_frame_sequencer_if.sv
// Link between the frame sequencer (master) and the center_of_mass accumulator (slave).
interface com_frame_sequencer_if;

  logic [com_frame_sequencer_pkg::X_W-1:0] com_x_out;
  logic [com_frame_sequencer_pkg::Y_W-1:0] com_y_out;
  logic                                    com_valid_out;
  logic                                    com_tabulate_out;
  logic                                    com_clear_out;
  logic [com_frame_sequencer_pkg::X_W-1:0] com_x_in;
  logic [com_frame_sequencer_pkg::Y_W-1:0] com_y_in;
  logic                                    com_valid_in;

  modport master (
    output com_x_out, com_y_out, com_valid_out, com_tabulate_out, com_clear_out,
    input  com_x_in, com_y_in, com_valid_in
  );

  modport slave (
    input  com_x_out, com_y_out, com_valid_out, com_tabulate_out, com_clear_out,
    output com_x_in, com_y_in, com_valid_in
  );

endinterface

// File: rtl/com_frame_sequencer.sv
// Frame-level controller: gates one frame of masked pixels into the COM accumulator,
// requests tabulation, waits for the result with a timeout and tracks lock.
module com_frame_sequencer
  import com_frame_sequencer_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int MIN_PIXELS   = 16,
  parameter int DRAIN_CYCLES = 2,
  parameter int TAB_TIMEOUT  = 4096,
  parameter int MISS_LIMIT   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [X_W-1:0]         hcount_in,
  input  logic [Y_W-1:0]         vcount_in,
  input  logic                   pixel_valid_in,
  input  logic                   mask_in,
  com_frame_sequencer_if.master  com,
  output logic [X_W-1:0]         x_out,
  output logic [Y_W-1:0]         y_out,
  output logic                   position_valid_out,
  output logic                   locked_out,
  output logic                   timeout_out
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int TMR_W = $clog2(TAB_TIMEOUT + 1);
  localparam int MIS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TAB_LAST   = TMR_W'(TAB_TIMEOUT - 1);
  localparam logic [MIS_W-1:0] MISS_MAX   = MIS_W'(MISS_LIMIT);
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_PIXELS);
  localparam logic [X_W-1:0]   LAST_COL   = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]   LAST_ROW   = Y_W'(V_ACTIVE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [MIS_W-1:0] miss_q, miss_d;
  logic [X_W-1:0]   x_q, x_d, cx_q, cx_d;
  logic [Y_W-1:0]   y_q, y_d, cy_q, cy_d;
  logic             pos_valid_q, pos_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             cvalid_q, cvalid_d;
  logic             tab_q, tab_d;
  logic             clr_q, clr_d;
  logic             sof, eof, fwd;

  assign sof = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign eof = pixel_valid_in && (hcount_in == LAST_COL) && (vcount_in == LAST_ROW);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    drain_d     = drain_q;
    tmr_d       = tmr_q;
    miss_d      = miss_q;
    x_d         = x_q;
    y_d         = y_q;
    pos_valid_d = 1'b0;
    timeout_d   = timeout_q;
    clr_d       = 1'b0;
    fwd         = 1'b0;

    case (state_q)
      CLEAR: begin
        clr_d     = 1'b1;
        pix_cnt_d = '0;
        state_d   = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (sof) begin
          fwd     = mask_in;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // A second SOF means the frame was truncated; drop it without counting a miss.
        if (sof) begin
          state_d = CLEAR;
        end else begin
          fwd = pixel_valid_in && mask_in;
          if (eof) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          tmr_d   = '0;
          state_d = (pix_cnt_q < MIN_CNT) ? MISS : TAB;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      TAB: begin
        if (com.com_valid_in) begin
          x_d         = com.com_x_in;
          y_d         = com.com_y_in;
          pos_valid_d = 1'b1;
          miss_d      = '0;
          state_d     = RESULT;
        end else if (tmr_q == TAB_LAST) begin
          timeout_d = 1'b1;
          state_d   = MISS;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RESULT: state_d = CLEAR;
      MISS: begin
        miss_d  = (miss_q >= MISS_MAX) ? MISS_MAX : miss_q + MIS_W'(1);
        state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase

    if (fwd) pix_cnt_d = sat_inc(pix_cnt_q);

    cvalid_d = fwd;
    cx_d     = fwd ? hcount_in : cx_q;
    cy_d     = fwd ? vcount_in : cy_q;
    tab_d    = (state_d == TAB);
    locked_d = (miss_d < MISS_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= CLEAR;
      pix_cnt_q   <= '0;
      drain_q     <= '0;
      tmr_q       <= '0;
      miss_q      <= MISS_MAX;
      x_q         <= '0;
      y_q         <= '0;
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      cvalid_q    <= 1'b0;
      tab_q       <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      drain_q     <= drain_d;
      tmr_q       <= tmr_d;
      miss_q      <= miss_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pos_valid_q <= pos_valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      cvalid_q    <= cvalid_d;
      tab_q       <= tab_d;
      clr_q       <= clr_d;
    end
  end

  assign com.com_x_out        = cx_q;
  assign com.com_y_out        = cy_q;
  assign com.com_valid_out    = cvalid_q;
  assign com.com_tabulate_out = tab_q;
  assign com.com_clear_out    = clr_q;
  assign x_out                = x_q;
  assign y_out                = y_q;
  assign position_valid_out   = pos_valid_q;
  assign locked_out           = locked_q;
  assign timeout_out          = timeout_q;

endmodule

// File: tb/tb_com_frame_sequencer.sv
// Directed bench: two sequencers (MIN_PIXELS 16 and 1) each driving a small behavioural COM accumulator.
module tb_com_frame_sequencer;
  import com_frame_sequencer_pkg::*;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b1;
  logic [X_W-1:0] hcount = '0;
  logic [Y_W-1:0] vcount = '0;
  logic           pvalid = 1'b0;
  logic           mask   = 1'b0;

  logic [X_W-1:0] x_a, x_b;
  logic [Y_W-1:0] y_a, y_b;
  logic           pv_a, pv_b, lock_a, lock_b, to_a, to_b;

  int   checks = 0;
  int   errors = 0;
  int   pos_a = 0, pos_b = 0, tab_a = 0, clr_a = 0;
  logic a_mute = 1'b0;

  always #5 clk_in = ~clk_in;

  com_frame_sequencer_if ca ();
  com_frame_sequencer_if cb ();

  com_frame_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount), .vcount_in(vcount),
    .pixel_valid_in(pvalid), .mask_in(mask), .com(ca),
    .x_out(x_a), .y_out(y_a), .position_valid_out(pv_a), .locked_out(lock_a), .timeout_out(to_a)
  );

  com_frame_sequencer #(.MIN_PIXELS(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount), .vcount_in(vcount),
    .pixel_valid_in(pvalid), .mask_in(mask), .com(cb),
    .x_out(x_b), .y_out(y_b), .position_valid_out(pv_b), .locked_out(lock_b), .timeout_out(to_b)
  );

  // Behavioural COM: sum on valid, clear on clear, answer mean 4 cycles into tabulate.
  logic [31:0] a_sx, a_sy, a_n, b_sx, b_sy, b_n;
  logic [2:0]  a_dly, b_dly;
  logic        a_done, b_done;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_sx <= 0; a_sy <= 0; a_n <= 0; a_dly <= 0; a_done <= 1'b0;
      ca.com_valid_in <= 1'b0; ca.com_x_in <= '0; ca.com_y_in <= '0;
    end else begin
      ca.com_valid_in <= 1'b0;
      if (ca.com_clear_out) begin
        a_sx <= 0; a_sy <= 0; a_n <= 0;
      end else if (ca.com_valid_out) begin
        a_sx <= a_sx + 32'(ca.com_x_out); a_sy <= a_sy + 32'(ca.com_y_out); a_n <= a_n + 1;
      end
      if (!ca.com_tabulate_out) begin
        a_dly <= 0; a_done <= 1'b0;
      end else if (!a_done) begin
        if (a_dly == 3'd3) begin
          a_done <= 1'b1;
          if (!a_mute) begin
            ca.com_valid_in <= 1'b1;
            ca.com_x_in <= X_W'((a_n == 0) ? 0 : a_sx / a_n);
            ca.com_y_in <= Y_W'((a_n == 0) ? 0 : a_sy / a_n);
          end
        end else a_dly <= a_dly + 3'd1;
      end
    end
  end

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      b_sx <= 0; b_sy <= 0; b_n <= 0; b_dly <= 0; b_done <= 1'b0;
      cb.com_valid_in <= 1'b0; cb.com_x_in <= '0; cb.com_y_in <= '0;
    end else begin
      cb.com_valid_in <= 1'b0;
      if (cb.com_clear_out) begin
        b_sx <= 0; b_sy <= 0; b_n <= 0;
      end else if (cb.com_valid_out) begin
        b_sx <= b_sx + 32'(cb.com_x_out); b_sy <= b_sy + 32'(cb.com_y_out); b_n <= b_n + 1;
      end
      if (!cb.com_tabulate_out) begin
        b_dly <= 0; b_done <= 1'b0;
      end else if (!b_done) begin
        if (b_dly == 3'd3) begin
          b_done <= 1'b1;
          cb.com_valid_in <= 1'b1;
          cb.com_x_in <= X_W'((b_n == 0) ? 0 : b_sx / b_n);
          cb.com_y_in <= Y_W'((b_n == 0) ? 0 : b_sy / b_n);
        end else b_dly <= b_dly + 3'd1;
      end
    end
  end

  always @(posedge clk_in) begin
    if (pv_a) pos_a <= pos_a + 1;
    if (pv_b) pos_b <= pos_b + 1;
    if (ca.com_tabulate_out) tab_a <= tab_a + 1;
    if (ca.com_clear_out) clr_a <= clr_a + 1;
  end

  task automatic pix(input int x, input int y, input logic m);
    @(negedge clk_in);
    hcount = X_W'(x); vcount = Y_W'(y); pvalid = 1'b1; mask = m;
  endtask

  task automatic idle(input int n);
    @(negedge clk_in);
    pvalid = 1'b0; mask = 1'b0;
    repeat (n - 1) @(negedge clk_in);
  endtask

  task automatic square_frame();
    pix(0, 0, 1'b0);
    for (int y = 50; y < 70; y++)
      for (int x = 100; x < 120; x++) pix(x, y, 1'b1);
    pix(1023, 767, 1'b0);
    idle(60);
  endtask

  task automatic small_frame(input int n);
    pix(0, 0, 1'b0);
    for (int i = 0; i < n; i++) pix(10 + i, 20, 1'b1);
    pix(1023, 767, 1'b0);
    idle(60);
  endtask

  task automatic test_reset();
    logic [X_W+Y_W+X_W+Y_W+7:0] v;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    v = {x_a, y_a, pv_a, lock_a, to_a, ca.com_x_out, ca.com_y_out,
         ca.com_valid_out, ca.com_tabulate_out, ca.com_clear_out};
    checks++; if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if (ca.com_clear_out !== 1'b1) begin errors++; $display("FAIL clear_after_reset: got %b expected 1", ca.com_clear_out); end
    @(negedge clk_in);
    checks++; if (ca.com_clear_out !== 1'b0) begin errors++; $display("FAIL clear_one_cycle: got %b expected 0", ca.com_clear_out); end
    checks++; if (lock_a !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", lock_a); end
  endtask

  task automatic test_square();
    int p0;
    p0 = pos_a;
    pix(0, 0, 1'b0);
    @(posedge clk_in); #1;
    checks++; if (ca.com_valid_out !== 1'b0) begin errors++; $display("FAIL sof_unmasked_fwd: got %b expected 0", ca.com_valid_out); end
    pix(100, 50, 1'b1);
    @(posedge clk_in); #1;
    checks++;
    if ({ca.com_valid_out, ca.com_x_out, ca.com_y_out} !== {1'b1, 11'd100, 10'd50}) begin
      errors++; $display("FAIL fwd_latency: got v=%b x=%0d y=%0d expected v=1 x=100 y=50",
                          ca.com_valid_out, ca.com_x_out, ca.com_y_out);
    end
    for (int y = 50; y < 70; y++)
      for (int x = 100; x < 120; x++)
        if (!(x == 100 && y == 50)) pix(x, y, 1'b1);
    pix(1023, 767, 1'b0);
    idle(60);
    checks++; if (pos_a - p0 != 1) begin errors++; $display("FAIL square_pulses: got %0d expected 1", pos_a - p0); end
    checks++; if (x_a !== 11'd109) begin errors++; $display("FAIL square_x: got %0d expected 109", x_a); end
    checks++; if (y_a !== 10'd59) begin errors++; $display("FAIL square_y: got %0d expected 59", y_a); end
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL square_locked: got %b expected 1", lock_a); end
  endtask

  task automatic test_min_pixels();
    int p0, t0;
    p0 = pos_a; t0 = tab_a;
    small_frame(5);
    checks++; if (tab_a - t0 != 0) begin errors++; $display("FAIL small_no_tab: got %0d expected 0", tab_a - t0); end
    checks++; if (pos_a - p0 != 0) begin errors++; $display("FAIL small_no_pulse: got %0d expected 0", pos_a - p0); end
    checks++; if ({x_a, y_a} !== {11'd109, 10'd59}) begin errors++; $display("FAIL small_pos_held: got %0d,%0d expected 109,59", x_a, y_a); end
    small_frame(5);
    small_frame(5);
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL locked_after_3_miss: got %b expected 1", lock_a); end
    small_frame(5);
    checks++; if (lock_a !== 1'b0) begin errors++; $display("FAIL locked_after_4_miss: got %b expected 0", lock_a); end
    p0 = pos_a;
    small_frame(16);
    checks++; if (pos_a - p0 != 1) begin errors++; $display("FAIL min16_pulse: got %0d expected 1", pos_a - p0); end
    checks++; if ({x_a, y_a} !== {11'd17, 10'd20}) begin errors++; $display("FAIL min16_pos: got %0d,%0d expected 17,20", x_a, y_a); end
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL min16_locked: got %b expected 1", lock_a); end
  endtask

  task automatic test_truncated();
    int p0, t0, c0;
    p0 = pos_a; t0 = tab_a; c0 = clr_a;
    pix(0, 0, 1'b0);
    for (int i = 0; i < 10; i++) pix(500 + i, 10, 1'b1);
    pix(0, 0, 1'b0);
    pix(600, 400, 1'b1);
    pix(1023, 767, 1'b1);
    idle(30);
    checks++; if (clr_a - c0 != 1) begin errors++; $display("FAIL trunc_clear: got %0d expected 1", clr_a - c0); end
    checks++; if (tab_a - t0 != 0) begin errors++; $display("FAIL trunc_no_tab: got %0d expected 0", tab_a - t0); end
    checks++; if (pos_a - p0 != 0) begin errors++; $display("FAIL trunc_no_pulse: got %0d expected 0", pos_a - p0); end
    square_frame();
    checks++; if (pos_a - p0 != 1) begin errors++; $display("FAIL trunc_next_pulse: got %0d expected 1", pos_a - p0); end
    checks++; if ({x_a, y_a} !== {11'd109, 10'd59}) begin errors++; $display("FAIL trunc_next_pos: got %0d,%0d expected 109,59", x_a, y_a); end
  endtask

  task automatic test_timeout();
    int p0, t0;
    small_frame(5);
    small_frame(15);
    small_frame(5);
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL pre_timeout_locked: got %b expected 1", lock_a); end
    a_mute = 1'b1;
    p0 = pos_a; t0 = tab_a;
    square_frame();
    repeat (4100) @(negedge clk_in);
    checks++; if (tab_a - t0 != 4096) begin errors++; $display("FAIL tab_cycles: got %0d expected 4096", tab_a - t0); end
    checks++; if (to_a !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b expected 1", to_a); end
    checks++; if (lock_a !== 1'b0) begin errors++; $display("FAIL timeout_miss: got %b expected 0", lock_a); end
    checks++; if (pos_a - p0 != 0) begin errors++; $display("FAIL timeout_no_pulse: got %0d expected 0", pos_a - p0); end
    checks++; if (x_a !== 11'd109) begin errors++; $display("FAIL timeout_x_held: got %0d expected 109", x_a); end
    a_mute = 1'b0;
    square_frame();
    checks++; if (pos_a - p0 != 1) begin errors++; $display("FAIL post_timeout_pulse: got %0d expected 1", pos_a - p0); end
    checks++; if (to_a !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", to_a); end
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL post_timeout_locked: got %b expected 1", lock_a); end
  endtask

  task automatic test_reset_in_tab();
    logic [X_W+Y_W+X_W+Y_W+7:0] v;
    logic seen;
    int p0;
    a_mute = 1'b1;
    square_frame();
    checks++; if (ca.com_tabulate_out !== 1'b1) begin errors++; $display("FAIL in_tab: got %b expected 1", ca.com_tabulate_out); end
    rst_in = 1'b1;
    #1;
    v = {x_a, y_a, pv_a, lock_a, to_a, ca.com_x_out, ca.com_y_out,
         ca.com_valid_out, ca.com_tabulate_out, ca.com_clear_out};
    checks++; if (v !== '0) begin errors++; $display("FAIL async_reset_outputs: got %h expected 0", v); end
    @(negedge clk_in);
    rst_in = 1'b0; a_mute = 1'b0;
    @(negedge clk_in);
    checks++; if (ca.com_clear_out !== 1'b1) begin errors++; $display("FAIL clear_after_midreset: got %b expected 1", ca.com_clear_out); end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix(200 + i, 100, 1'b1);
      @(posedge clk_in); #1;
      seen = seen | ca.com_valid_out;
    end
    idle(5);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wait_sof_ignores: got %b expected 0", seen); end
    p0 = pos_a;
    square_frame();
    checks++; if (pos_a - p0 != 1) begin errors++; $display("FAIL post_reset_pulse: got %0d expected 1", pos_a - p0); end
    checks++; if ({x_a, y_a} !== {11'd109, 10'd59}) begin errors++; $display("FAIL post_reset_pos: got %0d,%0d expected 109,59", x_a, y_a); end
  endtask

  task automatic test_single_pixel();
    int p0, t0;
    p0 = pos_b; t0 = tab_a;
    pix(0, 0, 1'b0);
    pix(466, 234, 1'b1);
    pix(1023, 767, 1'b0);
    idle(60);
    checks++; if (pos_b - p0 != 1) begin errors++; $display("FAIL single_pulse: got %0d expected 1", pos_b - p0); end
    checks++; if (x_b !== 11'd466) begin errors++; $display("FAIL single_x: got %0d expected 466", x_b); end
    checks++; if (y_b !== 10'd234) begin errors++; $display("FAIL single_y: got %0d expected 234", y_b); end
    checks++; if (tab_a - t0 != 0) begin errors++; $display("FAIL single_min16_no_tab: got %0d expected 0", tab_a - t0); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_min_pixels();
    test_truncated();
    test_timeout();
    test_reset_in_tab();
    test_single_pixel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
